// File: rtl/raw2rgb_bayer.sv
// rtl/raw2rgb_bayer.sv - Bayer CFA to RGB converter built on one line buffer and a sliding 2x2 window
module raw2rgb_bayer #(
  parameter int DW     = 10,
  parameter int LINE_W = 1280,
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 11
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          frame_start,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  input  logic [1:0]    pattern,
  input  logic          decim,
  output logic          data_valid_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out
);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_W - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        pattern_q, pattern_d;
  logic              decim_q, decim_d;
  logic              v1_q, v1_d;
  logic              elig1_q, elig1_d;
  logic [1:0]        phase1_q, phase1_d;
  logic [DW-1:0]     cur1_q, cur1_d;
  logic [DW-1:0]     above_q, above_d;
  logic [DW-1:0]     prev_cur_q, prev_cur_d;
  logic [DW-1:0]     prev_above_q, prev_above_d;
  logic              dvo_q, dvo_d;
  logic [DW-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;

  logic [DW-1:0]     line_mem [LINE_W];

  logic [ADDR_W-1:0] pix_col;
  logic [ROW_W-1:0]  pix_row;
  logic [1:0]        pix_pat;
  logic              pix_dec;
  logic              pix_elig;
  logic [DW-1:0]     tl, tr, bl, br;
  logic [DW-1:0]     r_win, g_win, b_win;

  function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW:1];
  endfunction

  // frame_start retargets the pixel presented in the same cycle, so it overrides counters and config here.
  always_comb begin
    pix_col  = frame_start ? '0 : col_q;
    pix_row  = frame_start ? '0 : row_q;
    pix_pat  = frame_start ? pattern : pattern_q;
    pix_dec  = frame_start ? decim : decim_q;
    pix_elig = (pix_row != '0) && (pix_col != '0) &&
               (!pix_dec || (pix_row[0] && pix_col[0]));

    col_d     = pix_col;
    row_d     = pix_row;
    pattern_d = pix_pat;
    decim_d   = pix_dec;
    if (data_valid) begin
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = pix_row + ROW_W'(1);
      end else begin
        col_d = pix_col + ADDR_W'(1);
      end
    end

    v1_d     = data_valid;
    elig1_d  = data_valid && pix_elig;
    phase1_d = data_valid ? (pix_pat ^ {~pix_row[0], ~pix_col[0]}) : phase1_q;
    cur1_d   = data_valid ? data : cur1_q;
    above_d  = data_valid ? line_mem[pix_col] : above_q;
  end

  // Window: previous pixel of each line sits in prev_*, newest column in above_q/cur1_q.
  always_comb begin
    tl = prev_above_q;
    tr = above_q;
    bl = prev_cur_q;
    br = cur1_q;
    prev_cur_d   = v1_q ? cur1_q : prev_cur_q;
    prev_above_d = v1_q ? above_q : prev_above_q;

    r_win = tl;
    g_win = avg2(tr, bl);
    b_win = br;
    case (phase1_q)
      2'd0: begin r_win = tl; g_win = avg2(tr, bl); b_win = br; end
      2'd1: begin r_win = tr; g_win = avg2(tl, br); b_win = bl; end
      2'd2: begin r_win = bl; g_win = avg2(tl, br); b_win = tr; end
      default: begin r_win = br; g_win = avg2(tr, bl); b_win = tl; end
    endcase

    dvo_d = v1_q && elig1_q;
    r_d   = dvo_d ? r_win : r_q;
    g_d   = dvo_d ? g_win : g_q;
    b_d   = dvo_d ? b_win : b_q;
  end

  always_ff @(posedge clk) begin
    if (data_valid) line_mem[pix_col] <= data;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      col_q        <= '0;
      row_q        <= '0;
      pattern_q    <= '0;
      decim_q      <= 1'b0;
      v1_q         <= 1'b0;
      elig1_q      <= 1'b0;
      phase1_q     <= '0;
      cur1_q       <= '0;
      above_q      <= '0;
      prev_cur_q   <= '0;
      prev_above_q <= '0;
      dvo_q        <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pattern_q    <= pattern_d;
      decim_q      <= decim_d;
      v1_q         <= v1_d;
      elig1_q      <= elig1_d;
      phase1_q     <= phase1_d;
      cur1_q       <= cur1_d;
      above_q      <= above_d;
      prev_cur_q   <= prev_cur_d;
      prev_above_q <= prev_above_d;
      dvo_q        <= dvo_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign data_valid_out = dvo_q;
  assign r_out          = r_q;
  assign g_out          = g_q;
  assign b_out          = b_q;
endmodule

// File: tb/tb_raw2rgb_bayer.sv
// tb/tb_raw2rgb_bayer.sv - randomized self-checking bench for raw2rgb_bayer against a CFA-colour model
module tb_raw2rgb_bayer;
  localparam int DW     = 10;
  localparam int LINE_W = 4;
  localparam int ADDR_W = 2;
  localparam int ROW_W  = 3;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          frame_start = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [1:0]    pattern = '0;
  logic          decim = 1'b0;
  logic          data_valid_out;
  logic [DW-1:0] r_out, g_out, b_out;

  raw2rgb_bayer #(.DW(DW), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .aclr(aclr), .frame_start(frame_start), .data_valid(data_valid),
    .data(data), .pattern(pattern), .decim(decim), .data_valid_out(data_valid_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] r, g, b;
  } exp_t;
  exp_t exp_q[$];
  exp_t cmp_e;
  logic [3*DW-1:0] obs[$];
  logic [DW-1:0] last_r = '0, last_g = '0, last_b = '0;

  // Model: image stored by row parity; colour of pixel (r,c) is pattern ^ {r[0],c[0]} (0=R, 3=B, else G).
  int m_row = 0, m_col = 0, m_pat = 0;
  bit m_dec = 1'b0;
  logic [DW-1:0] mline [2][LINE_W];

  task automatic model_pixel(input bit fs, input bit dv, input logic [DW-1:0] d,
                             input logic [1:0] pat, input bit dec);
    int rr[4], cc[4];
    int ph, gsum;
    logic [DW-1:0] v;
    exp_t e;
    if (fs) begin
      m_pat = int'(pat); m_dec = dec; m_row = 0; m_col = 0;
    end
    if (dv) begin
      mline[m_row % 2][m_col] = d;
      if (m_row != 0 && m_col != 0 && (!m_dec || (m_row % 2 == 1 && m_col % 2 == 1))) begin
        rr = '{m_row - 1, m_row - 1, m_row, m_row};
        cc = '{m_col - 1, m_col, m_col - 1, m_col};
        gsum = 0; e.r = '0; e.b = '0; e.due = cyc + 2;
        for (int k = 0; k < 4; k++) begin
          v  = mline[rr[k] % 2][cc[k]];
          ph = m_pat ^ (((rr[k] % 2) << 1) | (cc[k] % 2));
          if (ph == 0) e.r = v;
          else if (ph == 3) e.b = v;
          else gsum += int'(v);
        end
        e.g = DW'(gsum / 2);
        exp_q.push_back(e);
      end
      m_col++;
      if (m_col == LINE_W) begin
        m_col = 0;
        m_row = (m_row + 1) % (1 << ROW_W);
      end
    end
  endtask

  task automatic drive(input bit fs, input bit dv, input logic [DW-1:0] d,
                       input logic [1:0] pat, input bit dec);
    frame_start = fs; data_valid = dv; data = d; pattern = pat; decim = dec;
    model_pixel(fs, dv, d, pat, dec);
    @(posedge clk); #1;
    frame_start = 1'b0; data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, DW'($urandom), 2'($urandom), 1'($urandom));
  endtask

  task automatic two_rows(input logic [1:0] pat, input bit dec, input int base);
    for (int i = 0; i < 8; i++)
      drive(i == 0, 1'b1, DW'(base * (i + 1)), (i == 0) ? pat : 2'($urandom),
            (i == 0) ? dec : 1'($urandom));
    idle(4);
  endtask

  task automatic lit_count(input string name, input int n);
    checks++;
    if (obs.size() != n) begin
      errors++;
      $display("FAIL %s strobe count got %0d want %0d", name, obs.size(), n);
    end
  endtask

  task automatic lit_rgb(input string name, input int idx, input int r, input int g, input int b);
    logic [3*DW-1:0] want, got;
    checks++;
    want = {DW'(r), DW'(g), DW'(b)};
    got  = (idx < obs.size()) ? obs[idx] : '1;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got r=%0d g=%0d b=%0d want r=%0d g=%0d b=%0d", name, idx,
               got[3*DW-1:2*DW], got[2*DW-1:DW], got[DW-1:0], r, g, b);
    end
  endtask

  task automatic pulse_reset();
    aclr = 1'b0;
    #1;
    checks++;
    if (data_valid_out !== 1'b0 || r_out !== '0 || g_out !== '0 || b_out !== '0) begin
      errors++;
      $display("FAIL async_clear got dvo=%b r=%0d g=%0d b=%0d want all 0",
               data_valid_out, r_out, g_out, b_out);
    end
    exp_q.delete();
    last_r = '0; last_g = '0; last_b = '0;
    m_row = 0; m_col = 0; m_pat = 0; m_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b1;
  endtask

  always @(negedge clk) begin
    if (data_valid_out === 1'b1) obs.push_back({r_out, g_out, b_out});
    checks++;
    if (!aclr) begin
      if (data_valid_out !== 1'b0 || r_out !== '0 || g_out !== '0 || b_out !== '0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got dvo=%b r=%0d g=%0d b=%0d want all 0",
                 cyc, data_valid_out, r_out, g_out, b_out);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      cmp_e = exp_q.pop_front();
      if (data_valid_out !== 1'b1 || r_out !== cmp_e.r || g_out !== cmp_e.g || b_out !== cmp_e.b) begin
        errors++;
        $display("FAIL strobe cyc=%0d got dvo=%b r=%0d g=%0d b=%0d want dvo=1 r=%0d g=%0d b=%0d",
                 cyc, data_valid_out, r_out, g_out, b_out, cmp_e.r, cmp_e.g, cmp_e.b);
      end
      last_r = cmp_e.r; last_g = cmp_e.g; last_b = cmp_e.b;
    end else begin
      if (data_valid_out !== 1'b0 || r_out !== last_r || g_out !== last_g || b_out !== last_b) begin
        errors++;
        $display("FAIL hold cyc=%0d got dvo=%b r=%0d g=%0d b=%0d want dvo=0 r=%0d g=%0d b=%0d",
                 cyc, data_valid_out, r_out, g_out, b_out, last_r, last_g, last_b);
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe due=%0d now=%0d", exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    aclr = 1'b1;

    obs.delete();
    two_rows(2'd0, 1'b1, 10);
    lit_count("rggb_decim", 2);
    lit_rgb("rggb_decim", 0, 10, 35, 60);
    lit_rgb("rggb_decim", 1, 30, 55, 80);

    obs.delete();
    two_rows(2'd0, 1'b0, 10);
    lit_count("rggb_full", 3);
    lit_rgb("rggb_full", 0, 10, 35, 60);
    lit_rgb("rggb_full", 1, 30, 45, 60);
    lit_rgb("rggb_full", 2, 30, 55, 80);

    obs.delete();
    two_rows(2'd3, 1'b1, 10);
    lit_count("bggr_decim", 2);
    lit_rgb("bggr_decim", 0, 60, 35, 10);
    lit_rgb("bggr_decim", 1, 80, 55, 30);

    obs.delete();
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, DW'(1023), 2'd0, 1'b1);
      idle(2);
    end
    idle(3);
    lit_count("gapped_sat", 2);
    lit_rgb("gapped_sat", 0, 1023, 1023, 1023);
    lit_rgb("gapped_sat", 1, 1023, 1023, 1023);

    for (int i = 0; i < 6; i++) drive(i == 0, 1'b1, DW'(10 * (i + 1)), 2'd0, 1'b1);
    idle(4);
    obs.delete();
    drive(1'b1, 1'b1, DW'(100), 2'd1, 1'b1);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, DW'(100 * (i + 1)), 2'd2, 1'b0);
    idle(4);
    lit_count("resync_grbg", 2);
    lit_rgb("resync_grbg", 0, 200, 350, 500);
    lit_rgb("resync_grbg", 1, 400, 550, 700);

    obs.delete();
    for (int i = 0; i < 6; i++) drive(i == 0, 1'b1, DW'(10 * (i + 1)), 2'd0, 1'b1);
    pulse_reset();
    idle(3);
    lit_count("reset_drop", 0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, DW'(10 * (i + 1)), 2'($urandom), 1'($urandom));
    idle(4);
    lit_count("after_reset", 3);
    lit_rgb("after_reset", 0, 10, 35, 60);
    lit_rgb("after_reset", 1, 30, 45, 60);
    lit_rgb("after_reset", 2, 30, 55, 80);

    for (int f = 0; f < 8; f++) begin
      int n;
      drive(1'b1, 1'($urandom), DW'($urandom), 2'($urandom), 1'($urandom));
      n = LINE_W * $urandom_range(6, 14);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 99) < 2)
          drive(1'b1, 1'($urandom), DW'($urandom), 2'($urandom), 1'($urandom));
        else
          drive(1'b0, $urandom_range(0, 99) < 75, DW'($urandom), 2'($urandom), 1'($urandom));
      end
    end
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
